// File: rtl/instr_fetch_engine.sv
// ---------------------------------------------------------------------------
// instr_fetch_engine
//   Fetch-side producer for the IF/ID pipeline register. Owns the fetch PC,
//   issues req/ack reads to instruction memory (wait states allowed), buffers
//   returned words in a small prefetch FIFO and presents the FIFO head as
//   {instr, pc, pc+4}. Downstream STALL holds the head. FLUSH discards all
//   buffered and in-flight fetches and restarts fetching at FLUSH_PC.
//
// Ports
//   CLK               in   clock, rising edge
//   RESET             in   asynchronous, active-low reset
//   STALL             in   downstream holds; FIFO head not consumed
//   FLUSH             in   discard buffered/in-flight fetches, restart at FLUSH_PC
//   FLUSH_PC[31:0]    in   redirect target (bits [1:0] ignored)
//   IMem_Req          out  read request (registered)
//   IMem_Addr[31:0]   out  read address (registered, word aligned)
//   IMem_Ack          in   read complete; IMem_Data valid this cycle
//   IMem_Data[31:0]   in   read data
//   Instr1_IF[31:0]   out  head instruction, 0 when FIFO empty
//   Instr_PC_IF[31:0] out  head PC, 0 when FIFO empty
//   Instr_PC_Plus4_IF out  head PC+4 (wrapping), 0 when FIFO empty
//   Instr_Valid_IF    out  FIFO non-empty
// ---------------------------------------------------------------------------
module instr_fetch_engine #(
    parameter logic [31:0] RESET_PC = 32'h00400000,
    parameter int          QDEPTH   = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic [31:0] FLUSH_PC,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    output logic [31:0] Instr1_IF,
    output logic [31:0] Instr_PC_IF,
    output logic [31:0] Instr_PC_Plus4_IF,
    output logic        Instr_Valid_IF
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state_reg;
    logic            req_reg;
    logic [31:0]     addr_reg;
    logic [31:0]     fetch_pc_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;

    logic [31:0]     instr_mem [QDEPTH];
    logic [31:0]     pc_mem    [QDEPTH];

    logic [31:0]     flush_target;
    logic            pop;
    logic            push;
    logic            space;
    logic [CW:0]     occ_next;

    assign flush_target = FLUSH_PC & ~32'd3;

    // FLUSH suppresses both pop and push; the FIFO is emptied instead.
    assign pop  = (count_reg != '0) && !STALL && !FLUSH;
    assign push = (state_reg == REQ) && IMem_Ack && !FLUSH;

    // Occupancy after this edge decides whether another request may be issued,
    // so an accepted request always has a free slot when its data returns.
    assign occ_next = {1'b0, count_reg} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    assign space    = occ_next < (CW + 1)'(QDEPTH);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request FSM
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg    <= IDLE;
            req_reg      <= 1'b0;
            addr_reg     <= '0;
            fetch_pc_reg <= RESET_PC;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (FLUSH) begin
                        fetch_pc_reg <= flush_target;
                    end else if (space) begin
                        req_reg      <= 1'b1;
                        addr_reg     <= fetch_pc_reg;
                        fetch_pc_reg <= fetch_pc_reg + 32'd4;
                        state_reg    <= REQ;
                    end
                end
                REQ: begin
                    if (IMem_Ack) begin
                        if (FLUSH) begin
                            // Response is stale; reissue straight to the target.
                            addr_reg     <= flush_target;
                            fetch_pc_reg <= flush_target + 32'd4;
                        end else if (space) begin
                            addr_reg     <= fetch_pc_reg;
                            fetch_pc_reg <= fetch_pc_reg + 32'd4;
                        end else begin
                            req_reg   <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else if (FLUSH) begin
                        // Address must stay stable until the ack; remember to drop it.
                        fetch_pc_reg <= flush_target;
                        state_reg    <= DROP;
                    end
                end
                DROP: begin
                    if (IMem_Ack) begin
                        if (FLUSH) begin
                            addr_reg     <= flush_target;
                            fetch_pc_reg <= flush_target + 32'd4;
                        end else begin
                            addr_reg     <= fetch_pc_reg;
                            fetch_pc_reg <= fetch_pc_reg + 32'd4;
                        end
                        state_reg <= REQ;
                    end else if (FLUSH) begin
                        fetch_pc_reg <= flush_target;
                    end
                end
                default: begin
                    req_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // FIFO occupancy and pointers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (FLUSH) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= occ_next[CW-1:0];
        end
    end

    // FIFO storage; contents are only observed when count is non-zero.
    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= IMem_Data;
            pc_mem[wr_ptr_reg]    <= addr_reg;
        end
    end

    assign IMem_Req          = req_reg;
    assign IMem_Addr         = addr_reg;
    assign Instr_Valid_IF    = (count_reg != '0);
    assign Instr1_IF         = Instr_Valid_IF ? instr_mem[rd_ptr_reg] : '0;
    assign Instr_PC_IF       = Instr_Valid_IF ? pc_mem[rd_ptr_reg] : '0;
    assign Instr_PC_Plus4_IF = Instr_Valid_IF ? pc_mem[rd_ptr_reg] + 32'd4 : '0;

endmodule

// File: tb/tb_instr_fetch_engine.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_engine
//   Randomized bench for instr_fetch_engine. A memory responder answers
//   requests with data derived from the address after a random number of
//   wait states. The expected instruction stream (consecutive PCs from the
//   reset PC or the latest flush target) is queued by the stimulus; a monitor
//   pops it on every consumed head and compares. Directed steps cover reset,
//   latency, wait states, stall back-pressure, flush cases and PC wrap.
// ---------------------------------------------------------------------------
module tb_instr_fetch_engine;

    localparam logic [31:0] RPC = 32'h00400000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        STALL = 1'b0;
    logic        FLUSH = 1'b0;
    logic [31:0] FLUSH_PC = '0;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack = 1'b0;
    logic [31:0] IMem_Data = '0;
    logic [31:0] Instr1_IF;
    logic [31:0] Instr_PC_IF;
    logic [31:0] Instr_PC_Plus4_IF;
    logic        Instr_Valid_IF;

    instr_fetch_engine #(.RESET_PC(RPC), .QDEPTH(2)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .STALL             (STALL),
        .FLUSH             (FLUSH),
        .FLUSH_PC          (FLUSH_PC),
        .IMem_Req          (IMem_Req),
        .IMem_Addr         (IMem_Addr),
        .IMem_Ack          (IMem_Ack),
        .IMem_Data         (IMem_Data),
        .Instr1_IF         (Instr1_IF),
        .Instr_PC_IF       (Instr_PC_IF),
        .Instr_PC_Plus4_IF (Instr_PC_Plus4_IF),
        .Instr_Valid_IF    (Instr_Valid_IF)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int min_wait = 0;
    int max_wait = 0;
    int n_pops   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    // Memory content is a fixed function of the word address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a ^ 32'h5A3C96E1) + {a[7:0], a[31:8]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Expected stream after a reset or redirect: consecutive words from start.
    task automatic sb_restart(input logic [31:0] start);
        exp_t e;
        sb.delete();
        for (int i = 0; i < 300; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = memf(e.pc);
            sb.push_back(e);
        end
    endtask

    // Stimulus phase: 2 time units after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Memory responder: acts 1 time unit after the rising edge.
    initial begin
        int wl;
        wl = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (IMem_Ack) begin
                IMem_Ack = 1'b0;
                wl = int'($urandom_range(max_wait, min_wait));
            end
            if (!RESET) begin
                IMem_Ack = 1'b0;
                wl = int'($urandom_range(max_wait, min_wait));
            end else if (IMem_Req) begin
                if (wl == 0) begin
                    IMem_Ack  = 1'b1;
                    IMem_Data = memf(IMem_Addr);
                end else begin
                    wl--;
                    IMem_Data = $urandom;
                end
            end else begin
                IMem_Data = $urandom;
            end
        end
    end

    // Monitor / scoreboard: samples on the falling edge.
    initial begin
        logic        p_req;
        logic        p_ack;
        logic        p_rst;
        logic [31:0] p_addr;
        exp_t        e;
        p_req = 1'b0; p_ack = 1'b0; p_rst = 1'b0; p_addr = '0;
        forever begin
            @(negedge CLK);
            if (RESET && p_rst && p_req && !p_ack) begin
                check("req_held", IMem_Req, 1);
                check("addr_held", IMem_Addr, p_addr);
            end
            if (!Instr_Valid_IF) begin
                check("empty_instr", Instr1_IF, 0);
                check("empty_pc", Instr_PC_IF, 0);
                check("empty_plus4", Instr_PC_Plus4_IF, 0);
            end else if (RESET && !STALL && !FLUSH) begin
                if (sb.size() == 0) begin
                    fail_now("scoreboard_empty");
                end else begin
                    e = sb.pop_front();
                    n_pops++;
                    $display("pop pc=%h instr=%h plus4=%h", Instr_PC_IF, Instr1_IF, Instr_PC_Plus4_IF);
                    check("head_pc", Instr_PC_IF, e.pc);
                    check("head_instr", Instr1_IF, e.instr);
                    check("head_plus4", Instr_PC_Plus4_IF, e.pc + 32'd4);
                end
            end
            p_req  = IMem_Req;
            p_ack  = IMem_Ack;
            p_addr = IMem_Addr;
            p_rst  = RESET;
        end
    end

    // Holds reset for three cycles, checks the reset state, then releases.
    task automatic do_reset();
        RESET = 1'b0;
        STALL = 1'b0;
        FLUSH = 1'b0;
        sb_restart(RPC);
        repeat (3) tick();
        check("rst_req", IMem_Req, 0);
        check("rst_addr", IMem_Addr, 0);
        check("rst_valid", Instr_Valid_IF, 0);
        check("rst_instr", Instr1_IF, 0);
        RESET = 1'b1;
    endtask

    task automatic do_flush(input logic [31:0] target);
        FLUSH    = 1'b1;
        FLUSH_PC = target;
        sb_restart(target & ~32'd3);
        tick();
        FLUSH = 1'b0;
    endtask

    initial begin
        logic [31:0] hpc;
        logic        pv;
        int          k;

        // 1: reset, zero-wait memory, latency and throughput
        min_wait = 0; max_wait = 0;
        tick();
        do_reset();
        tick();
        check("t1_req", IMem_Req, 1);
        check("t1_addr", IMem_Addr, RPC);
        check("t1_valid", Instr_Valid_IF, 0);
        tick();
        check("t1_valid2", Instr_Valid_IF, 1);
        check("t1_pc0", Instr_PC_IF, RPC);
        check("t1_p4_0", Instr_PC_Plus4_IF, RPC + 32'd4);
        tick();
        check("t1_pc1", Instr_PC_IF, RPC + 32'd4);
        tick();
        check("t1_pc2", Instr_PC_IF, RPC + 32'd8);

        // 2: three wait states per request; heads never back to back
        min_wait = 3; max_wait = 3;
        repeat (6) tick();
        pv = Instr_Valid_IF;
        for (int i = 0; i < 24; i++) begin
            tick();
            check("t2_no_b2b", pv && Instr_Valid_IF, 0);
            pv = Instr_Valid_IF;
        end

        // 3: stall fills the FIFO, request drops, head frozen
        min_wait = 0; max_wait = 0;
        repeat (8) tick();
        check("t3_valid_pre", Instr_Valid_IF, 1);
        hpc = Instr_PC_IF;
        STALL = 1'b1;
        repeat (5) tick();
        check("t3_req", IMem_Req, 0);
        check("t3_valid", Instr_Valid_IF, 1);
        check("t3_head", Instr_PC_IF, hpc);
        STALL = 1'b0;
        repeat (6) tick();

        // 4: flush while the request to RPC+8 is outstanding
        min_wait = 3; max_wait = 3;
        do_reset();
        k = 0;
        while (!(IMem_Req && !IMem_Ack && IMem_Addr == RPC + 32'd8) && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) fail_now("t4_wait_req");
        do_flush(32'h00400100);
        check("t4_valid", Instr_Valid_IF, 0);
        k = 0;
        while (IMem_Addr == RPC + 32'd8 && k < 20) begin
            tick();
            k++;
        end
        check("t4_next_addr", IMem_Addr, 32'h00400100);
        check("t4_req", IMem_Req, 1);
        repeat (20) tick();

        // 5: flush in the same cycle as an ack
        min_wait = 0; max_wait = 0;
        repeat (8) tick();
        k = 0;
        while (!(IMem_Req && IMem_Ack) && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) fail_now("t5_wait_ack");
        do_flush(32'h00400100);
        check("t5_req", IMem_Req, 1);
        check("t5_addr", IMem_Addr, 32'h00400100);
        check("t5_valid", Instr_Valid_IF, 0);
        repeat (5) tick();

        // 6: PC wrap
        do_flush(32'hFFFFFFFC);
        k = 0;
        while (!Instr_Valid_IF && k < 20) begin
            tick();
            k++;
        end
        check("t6_pc0", Instr_PC_IF, 32'hFFFFFFFC);
        check("t6_p4_0", Instr_PC_Plus4_IF, 32'h00000000);
        tick();
        check("t6_pc1", Instr_PC_IF, 32'h00000000);
        check("t6_p4_1", Instr_PC_Plus4_IF, 32'h00000004);

        // 6b: asynchronous reset in the middle of a request
        min_wait = 5; max_wait = 5;
        repeat (10) tick();
        k = 0;
        while (!(IMem_Req && !IMem_Ack) && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) fail_now("t6_wait_req");
        #1 RESET = 1'b0;
        #1;
        check("t6_rst_req", IMem_Req, 0);
        check("t6_rst_valid", Instr_Valid_IF, 0);
        check("t6_rst_addr", IMem_Addr, 0);
        sb_restart(RPC);
        tick();

        // Random phase
        min_wait = 0; max_wait = 2;
        do_reset();
        n_pops = 0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) max_wait = int'($urandom_range(4, 0));
            STALL = ($urandom_range(3, 0) == 0);
            if ($urandom_range(39, 0) == 0 || c % 200 == 199) begin
                do_flush($urandom);
            end else begin
                tick();
            end
        end
        STALL = 1'b0;
        repeat (10) tick();
        check("rand_pops_seen", (n_pops > 100) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
